// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: reads program words at fetch_pc into a small prefetch queue for the interpreter.
// Latency: address issued one edge after reset release/redirect; word visible one edge after mem_ready.
// Backpressure: a request is only issued when a queue slot is guaranteed; mem_ready low stalls the request.
module inst_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INST_W   = 16,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              done,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [INST_W-1:0] mem_data_in,
    input  logic              mem_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] q_pc  [QDEPTH];
    logic [INST_W-1:0] q_dat [QDEPTH];

    logic              push;
    logic              pop;
    logic [CW-1:0]     count_after;
    logic              free_after;

    // Queue bookkeeping for this edge; a redirect suppresses both push and pop.
    always_comb begin
        push        = (state == BUSY) && mem_ready && !pc_load;
        pop         = done && inst_valid && !pc_load;
        count_after = count + CW'(push) - CW'(pop);
        free_after  = (count_after < QFULL);
    end

    // Head of queue is presented from registered entries, forced to zero when empty.
    always_comb begin
        inst_valid = (count != '0);
        inst       = inst_valid ? q_dat[rd_ptr] : '0;
        inst_pc    = inst_valid ? q_pc[rd_ptr]  : '0;
    end

    // Queue storage: each returned word is tagged with the address it came from.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]  <= fetch_pc;
            q_dat[wr_ptr] <= mem_data_in;
        end
    end

    // Request FSM plus queue pointers; in BUSY fetch_pc always equals the outstanding mem_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (pc_load) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                fetch_pc <= pc_target;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                count <= count_after;
            end

            case (state)
                IDLE: begin
                    if (pc_load) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= pc_target;
                        state    <= BUSY;
                    end else if (free_after) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= fetch_pc;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (pc_load) begin
                        // Returned word (if any) is stale; either re-aim now or wait it out.
                        if (mem_ready) mem_addr <= pc_target;
                        else           state    <= DISCARD;
                    end else if (mem_ready) begin
                        fetch_pc <= fetch_pc + ADDR_W'(1);
                        if (free_after) begin
                            mem_addr <= fetch_pc + ADDR_W'(1);
                        end else begin
                            mem_rd <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    // Queue is empty here, so the redirected request can follow immediately.
                    if (mem_ready) begin
                        mem_addr <= pc_load ? pc_target : fetch_pc;
                        state    <= BUSY;
                    end
                end
                default: begin
                    mem_rd <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios with fixed expectations, then randomized traffic.
// The random phase models the instruction stream architecturally: next expected pc and word = f(pc).
// Memory responds combinationally with mem[a] = 16'hA500 | a; mem_ready is bench-controlled.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        done;
    logic        pc_load;
    logic [7:0]  pc_target;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data_in;
    logic        mem_ready;
    logic [15:0] inst;
    logic [7:0]  inst_pc;
    logic        inst_valid;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .done        (done),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_ready   (mem_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_in = 16'hA500 | {8'h00, mem_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [7:0] pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"},    32'(inst_pc),    32'(pc));
        chk({tag, "_inst"},  32'(inst),       32'(16'hA500 | {8'h00, pc}));
    endtask

    logic [7:0] exp_pc;
    logic       will_pop;
    logic       prev_rd;
    logic [7:0] prev_addr;
    int         pops;

    initial begin
        rst_n     = 1'b0;
        done      = 1'b0;
        pc_load   = 1'b0;
        pc_target = 8'h00;
        mem_ready = 1'b1;
        #2;
        chk("rst_mem_rd",     32'(mem_rd),     32'd0);
        chk("rst_mem_addr",   32'(mem_addr),   32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst",       32'(inst),       32'd0);
        chk("rst_inst_pc",    32'(inst_pc),    32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: fill queue
        tick();
        chk("fill_rd0",    32'(mem_rd),     32'd1);
        chk("fill_addr0",  32'(mem_addr),   32'h00);
        chk("fill_empty0", 32'(inst_valid), 32'd0);
        tick();
        chk("fill_addr1",  32'(mem_addr),   32'h01);
        chk_head("fill_h0", 8'h00);
        tick();
        chk("fill_rd_drop", 32'(mem_rd), 32'd0);
        chk_head("fill_h1", 8'h00);
        tick();
        chk("fill_rd_idle", 32'(mem_rd), 32'd0);
        chk_head("fill_h2", 8'h00);

        // 2: streaming with done held
        done = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_head("stream", 8'(i));
        end
        done = 1'b0;
        tick();

        // 3: wait states at 10
        pc_load = 1'b1; pc_target = 8'h10;
        tick();
        pc_load = 1'b0;
        chk("ws_empty", 32'(inst_valid), 32'd0);
        chk("ws_addr",  32'(mem_addr),   32'h10);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_hold_rd",   32'(mem_rd),     32'd1);
            chk("ws_hold_addr", 32'(mem_addr),   32'h10);
            chk("ws_no_push",   32'(inst_valid), 32'd0);
        end
        mem_ready = 1'b1;
        tick();
        chk_head("ws_entry", 8'h10);

        // 4: redirect while waiting at 07
        pc_load = 1'b1; pc_target = 8'h07;
        tick();
        chk("rd_flush",  32'(inst_valid), 32'd0);
        chk("rd_addr07", 32'(mem_addr),   32'h07);
        pc_load = 1'b0; mem_ready = 1'b0;
        tick();
        pc_load = 1'b1; pc_target = 8'h40;
        tick();
        pc_load = 1'b0;
        chk("rd_empty",     32'(inst_valid), 32'd0);
        chk("rd_hold_rd",   32'(mem_rd),     32'd1);
        chk("rd_hold_addr", 32'(mem_addr),   32'h07);
        tick();
        chk("rd_hold_addr2", 32'(mem_addr), 32'h07);
        mem_ready = 1'b1;
        tick();
        chk("rd_drop07", 32'(inst_valid), 32'd0);
        chk("rd_addr40", 32'(mem_addr),   32'h40);
        tick();
        chk_head("rd_first", 8'h40);

        // 5: redirect + mem_ready + done on one edge
        pc_load = 1'b1; pc_target = 8'h20; done = 1'b1;
        tick();
        pc_load = 1'b0; done = 1'b0;
        chk("sim_empty", 32'(inst_valid), 32'd0);
        chk("sim_addr",  32'(mem_addr),   32'h20);
        chk("sim_rd",    32'(mem_rd),     32'd1);
        tick();
        chk_head("sim_first", 8'h20);

        // 6: wrap, then reset mid-request
        pc_load = 1'b1; pc_target = 8'hFF; done = 1'b1;
        tick();
        pc_load = 1'b0;
        chk("wrap_empty", 32'(inst_valid), 32'd0);
        tick();
        chk_head("wrap_ff", 8'hFF);
        tick();
        chk_head("wrap_00", 8'h00);
        done = 1'b0; mem_ready = 1'b0;
        tick();
        chk("pre_rst_rd", 32'(mem_rd), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd",    32'(mem_rd),     32'd0);
        chk("arst_valid", 32'(inst_valid), 32'd0);
        chk("arst_addr",  32'(mem_addr),   32'd0);
        chk("arst_inst",  32'(inst),       32'd0);
        mem_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_rd",   32'(mem_rd),   32'd1);
        chk("restart_addr", 32'(mem_addr), 32'h00);
        tick();
        chk_head("restart_h", 8'h00);

        // Random traffic against the architectural stream model
        exp_pc = 8'h00;
        pops   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (inst_valid) begin
                chk("rnd_head_pc",   32'(inst_pc), 32'(exp_pc));
                chk("rnd_head_inst", 32'(inst),    32'(16'hA500 | {8'h00, exp_pc}));
            end
            mem_ready = ($urandom_range(0, 9) < 7);
            done      = ($urandom_range(0, 9) < 6);
            pc_load   = ($urandom_range(0, 99) < 5);
            pc_target = 8'($urandom);
            will_pop  = done && inst_valid && !pc_load;
            prev_rd   = mem_rd;
            prev_addr = mem_addr;
            tick();
            if (pc_load) begin
                exp_pc = pc_target;
                chk("rnd_flush", 32'(inst_valid), 32'd0);
            end else if (will_pop) begin
                exp_pc = exp_pc + 8'd1;
                pops++;
            end
            if (prev_rd && !mem_ready) begin
                chk("rnd_stall_rd",   32'(mem_rd),   32'd1);
                chk("rnd_stall_addr", 32'(mem_addr), 32'(prev_addr));
            end
        end
        chk("rnd_progress", 32'(pops > 300), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
